// File: rtl/dmem_io_if.sv
// dmem_io_if: core-side load/store bus between the CPU and the data memory / IO block
interface dmem_io_if;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master (output memwrite, aluout, writedata, input readdata);
  modport slave (input memwrite, aluout, writedata, output readdata);
endinterface

// File: rtl/dmem_io.sv
// dmem_io: word-addressed data RAM plus cycle counter, compare timer, and GPIO registers
module dmem_io #(
  parameter int RAM_WORDS = 64,
  parameter int GPIO_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  dmem_io_if.slave          bus,
  output logic [GPIO_W-1:0] gpio_out,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic              timer_irq
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam logic [31:0] CNT_A = 32'hFFFF_0000;
  localparam logic [31:0] CMP_A = 32'hFFFF_0004;
  localparam logic [31:0] STAT_A = 32'hFFFF_0008;
  localparam logic [31:0] GOUT_A = 32'hFFFF_000C;
  localparam logic [31:0] GIN_A = 32'hFFFF_0010;
  logic [31:0] ram [RAM_WORDS];
  logic [31:0] cnt, cmp;
  logic flag, en;
  logic [GPIO_W-1:0] sync1, sync2;
  logic ram_sel, wr_cnt, wr_cmp, wr_stat, wr_gout, match;
  assign ram_sel = bus.aluout < 32'(4 * RAM_WORDS);
  assign wr_cnt = bus.memwrite && bus.aluout == CNT_A;
  assign wr_cmp = bus.memwrite && bus.aluout == CMP_A;
  assign wr_stat = bus.memwrite && bus.aluout == STAT_A;
  assign wr_gout = bus.memwrite && bus.aluout == GOUT_A;
  assign match = cnt == cmp && cmp != '0;
  assign timer_irq = flag & en;
  always_ff @(posedge clk)
    if (bus.memwrite && ram_sel) ram[bus.aluout[AW+1:2]] <= bus.writedata;
  // match is taken from the pre-edge count, so it survives a same-edge CNT write and beats a W1C
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      cmp <= '0;
      flag <= 1'b0;
      en <= 1'b0;
      gpio_out <= '0;
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      cnt <= wr_cnt ? '0 : cnt + 32'd1;
      if (wr_cmp) cmp <= bus.writedata;
      flag <= match | (flag & ~(wr_stat & bus.writedata[0]));
      if (wr_stat) en <= bus.writedata[1];
      if (wr_gout) gpio_out <= bus.writedata[GPIO_W-1:0];
      sync1 <= gpio_in;
      sync2 <= sync1;
    end
  always_comb
    bus.readdata = ram_sel ? ram[bus.aluout[AW+1:2]] :
                   bus.aluout == CNT_A ? cnt :
                   bus.aluout == CMP_A ? cmp :
                   bus.aluout == STAT_A ? {30'd0, en, flag} :
                   bus.aluout == GOUT_A ? 32'(gpio_out) :
                   bus.aluout == GIN_A ? 32'(sync2) : '0;
endmodule

// File: tb/tb_dmem_io.sv
// tb_dmem_io: directed and randomized checks of dmem_io against a transaction-level model
module tb_dmem_io;
  localparam int RW = 64;
  localparam int GW = 8;
  localparam logic [31:0] CNT_A = 32'hFFFF_0000;
  localparam logic [31:0] CMP_A = 32'hFFFF_0004;
  localparam logic [31:0] STAT_A = 32'hFFFF_0008;
  localparam logic [31:0] GOUT_A = 32'hFFFF_000C;
  localparam logic [31:0] GIN_A = 32'hFFFF_0010;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [GW-1:0] gpio_out, gpio_in;
  logic timer_irq;
  int checks = 0;
  int failures = 0;
  dmem_io_if bus ();
  dmem_io #(.RAM_WORDS(RW), .GPIO_W(GW)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .gpio_out(gpio_out), .gpio_in(gpio_in), .timer_irq(timer_irq)
  );
  always #5 clk = ~clk;
  logic [31:0] m_ram [RW];
  bit m_ok [RW];
  logic [31:0] m_cnt, m_cmp;
  bit m_flag, m_en;
  logic [GW-1:0] m_gout;
  logic [GW-1:0] m_hist [2];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic bit is_ram(input logic [31:0] a);
    return a < 32'(4 * RW);
  endfunction
  function automatic int widx(input logic [31:0] a);
    return int'(a >> 2);
  endfunction
  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (is_ram(a)) return m_ram[widx(a)];
    if (a == CNT_A) return m_cnt;
    if (a == CMP_A) return m_cmp;
    if (a == STAT_A) return {30'd0, m_en, m_flag};
    if (a == GOUT_A) return 32'(m_gout);
    if (a == GIN_A) return 32'(m_hist[1]);
    return 32'd0;
  endfunction
  task automatic m_reset();
    m_cnt = 0; m_cmp = 0; m_flag = 0; m_en = 0; m_gout = 0;
    m_hist[0] = 0; m_hist[1] = 0;
  endtask
  task automatic m_edge(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [GW-1:0] gin);
    bit hit;
    hit = m_cnt == m_cmp && m_cmp != 0;
    if (we && is_ram(a)) begin m_ram[widx(a)] = wd; m_ok[widx(a)] = 1; end
    m_cnt = (we && a == CNT_A) ? 32'd0 : m_cnt + 32'd1;
    if (we && a == CMP_A) m_cmp = wd;
    if (we && a == STAT_A) begin
      if (wd[0]) m_flag = 0;
      m_en = wd[1];
    end
    if (hit) m_flag = 1;
    if (we && a == GOUT_A) m_gout = wd[GW-1:0];
    m_hist[1] = m_hist[0];
    m_hist[0] = gin;
  endtask
  task automatic step(input bit we, input logic [31:0] a, input logic [31:0] wd);
    bus.memwrite = we; bus.aluout = a; bus.writedata = wd;
    #1;
    if (!is_ram(a) || m_ok[widx(a)]) chk("model_rd", bus.readdata, m_read(a));
    chk("model_irq", 32'(timer_irq), 32'(m_flag & m_en));
    chk("model_gout", 32'(gpio_out), 32'(m_gout));
    @(posedge clk);
    m_edge(we, a, wd, gpio_in);
    @(negedge clk);
  endtask
  task automatic rdx(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.memwrite = 0; bus.aluout = a; bus.writedata = 0;
    #1;
    chk(tag, bus.readdata, exp);
    step(0, a, 0);
  endtask
  initial begin
    logic [31:0] a, wd;
    bus.memwrite = 0; bus.aluout = CNT_A; bus.writedata = 0; gpio_in = 0;
    m_reset();
    for (int i = 0; i < RW; i++) m_ok[i] = 0;
    #1;
    chk("rst_cnt", bus.readdata, 32'd0);
    chk("rst_gout", 32'(gpio_out), 32'd0);
    chk("rst_irq", 32'(timer_irq), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1;
    rdx("rel_cnt0", CNT_A, 32'd0);
    rdx("rel_cnt1", CNT_A, 32'd1);
    step(1, 32'h0, 32'hA5A5_A5A5);
    step(1, 32'h10, 32'hDEAD_BEEF);
    step(1, 32'h14, 32'h1234_5678);
    rdx("ram_10", 32'h10, 32'hDEAD_BEEF);
    rdx("ram_13", 32'h13, 32'hDEAD_BEEF);
    rdx("ram_14", 32'h14, 32'h1234_5678);
    step(1, 32'h1000, 32'h5555_5555);
    rdx("unmap_rd", 32'h1000, 32'd0);
    rdx("ram_alias", 32'h0, 32'hA5A5_A5A5);
    step(1, GOUT_A, 32'h1A5);
    chk("gout_a5", 32'(gpio_out), 32'hA5);
    step(1, GIN_A, 32'hFF);
    gpio_in = 8'h3C;
    rdx("gin_e0", GIN_A, 32'd0);
    rdx("gin_e1", GIN_A, 32'd0);
    rdx("gin_e2", GIN_A, 32'h3C);
    step(1, CMP_A, 32'd20);
    step(1, STAT_A, 32'h2);
    step(1, CNT_A, 32'd0);
    repeat (20) step(0, STAT_A, 0);
    chk("tmr_pre_irq", 32'(timer_irq), 32'd0);
    rdx("tmr_pre", STAT_A, 32'h2);
    chk("tmr_irq", 32'(timer_irq), 32'd1);
    rdx("tmr_flag", STAT_A, 32'h3);
    step(1, STAT_A, 32'h3);
    rdx("tmr_clr", STAT_A, 32'h2);
    step(1, CNT_A, 32'd0);
    repeat (20) step(0, STAT_A, 0);
    step(1, STAT_A, 32'h1);
    rdx("race", STAT_A, 32'h1);
    step(1, CMP_A, 32'd0);
    step(1, STAT_A, 32'h3);
    step(1, CNT_A, 32'd0);
    repeat (5) step(0, STAT_A, 0);
    rdx("cmp0", STAT_A, 32'h2);
    step(1, CMP_A, 32'hFFFF_FFFF);
    force dut.cnt = 32'hFFFF_FFFE;
    #1;
    release dut.cnt;
    m_cnt = 32'hFFFF_FFFE;
    rdx("wrap_fe", CNT_A, 32'hFFFF_FFFE);
    rdx("wrap_ff", CNT_A, 32'hFFFF_FFFF);
    rdx("wrap_0", CNT_A, 32'd0);
    rdx("wrap_flag", STAT_A, 32'h3);
    bus.memwrite = 1; bus.aluout = GOUT_A; bus.writedata = 32'h5A;
    #2;
    reset = 0;
    #1;
    chk("arst_gout", 32'(gpio_out), 32'd0);
    chk("arst_irq", 32'(timer_irq), 32'd0);
    bus.aluout = CNT_A; bus.memwrite = 0;
    #0.1;
    chk("arst_cnt", bus.readdata, 32'd0);
    m_reset();
    bus.aluout = GOUT_A; bus.memwrite = 1;
    @(posedge clk);
    @(negedge clk);
    chk("arst_wr", 32'(gpio_out), 32'd0);
    reset = 1;
    rdx("arst_c0", CNT_A, 32'd0);
    rdx("arst_c1", CNT_A, 32'd1);
    rdx("arst_ram", 32'h10, 32'hDEAD_BEEF);
    for (int i = 0; i < 600; i++) begin
      gpio_in = GW'($urandom);
      case ($urandom_range(0, 7))
        0, 1: a = ($urandom_range(0, RW - 1) << 2) | 32'($urandom_range(0, 3));
        2: a = CNT_A;
        3: a = CMP_A;
        4: a = STAT_A;
        5: a = GOUT_A;
        6: a = GIN_A;
        default: a = ($urandom_range(0, 1) == 1) ? 32'hFFFF_0014 : 32'h100 + 32'($urandom_range(0, 1000));
      endcase
      wd = (a == CMP_A && $urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 30)) : $urandom;
      step(($urandom_range(0, 1) == 1), a, wd);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_io.md
DMEM_IO -- requirements
Module: dmem_io

Interface
REQ-001 Parameter RAM_WORDS, default 64, number of 32-bit data RAM words (power of two, 16..256).
REQ-002 Parameter GPIO_W, default 8, width of the GPIO output and input buses.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 memwrite  input  1  write strobe from the core; a write commits on the rising clk edge while high.
REQ-006 aluout  input  32  byte address from the core; bits [1:0] are ignored (word access only).
REQ-007 writedata  input  32  store data from the core.
REQ-008 readdata  output  32  load data to the core, combinational from aluout.
REQ-009 gpio_out  output  GPIO_W  GPIO output register.
REQ-010 gpio_in  input  GPIO_W  asynchronous external inputs.
REQ-011 timer_irq  output  1  level interrupt, timer flag AND enable.

Function
REQ-012 The address map SHALL be as follows; decoding SHALL use full 32-bit compares.
  - RAM: 0x0000_0000 .. 4*RAM_WORDS-4, word index aluout[log2(RAM_WORDS)+1:2].
  - CNT 0xFFFF_0000: free-running cycle counter. Reads return the count; any write clears it.
  - CMP 0xFFFF_0004: timer compare value, R/W.
  - STAT 0xFFFF_0008: bit0 irq flag (write 1 clears it); bit1 irq enable (R/W); other bits read 0.
  - GOUT 0xFFFF_000C: gpio_out register, R/W on the low GPIO_W bits.
  - GIN 0xFFFF_0010: synchronized gpio_in, read-only.
REQ-013 Reads SHALL be zero-latency: readdata reflects the currently addressed location in the same cycle, with no clock.
REQ-014 An unmapped address SHALL read 0x0000_0000, and writes to it SHALL be ignored.
REQ-015 Writes SHALL take effect at the rising edge where memwrite=1. A read of the same address in the following cycle SHALL return the new value.
REQ-016 Writes to GIN SHALL be ignored. Register bits above the defined fields SHALL read 0.
REQ-017 CNT SHALL increment by 1 every cycle, wrapping from 0xFFFF_FFFF to 0x0000_0000.
REQ-018 A write to CNT SHALL load 0 in that edge, with no increment in that edge.
REQ-019 When CNT equals CMP and CMP is not 0, the flag SHALL be set at the next rising edge. The flag is sticky.
REQ-020 If a flag set and a STAT write-1-clear occur in the same edge, set SHALL win.
REQ-021 A STAT write SHALL update the enable bit from writedata[1] in the same edge as the clear.
REQ-022 If CNT is written in the same cycle as a compare match, the match from the pre-write value SHALL still set the flag.
REQ-023 gpio_in SHALL pass through a two-flop synchronizer. GIN reflects a gpio_in change 2 edges after it is sampled.
REQ-024 timer_irq SHALL be registered-state logic only: flag AND enable, with no glitch path from aluout.
REQ-025 RAM contents SHALL have no reset. Reads of never-written words are undefined (X in simulation).

Reset
REQ-026 While reset=0, regardless of clk: CNT, CMP, flag, enable, gpio_out and both synchronizer stages SHALL be 0, and timer_irq SHALL be 0.
REQ-027 Reset assertion mid-operation SHALL take effect immediately. A write coincident with reset SHALL be discarded for all registers (RAM behaviour undefined).
REQ-028 After deassertion, CNT SHALL read 0 in the first cycle, then 1 after the first rising edge.

Verification
REQ-029 RAM: write 0xDEADBEEF to 0x0000_0010, then 0x12345678 to 0x0000_0014. Read 0x10 -> 0xDEADBEEF, read 0x13 -> 0xDEADBEEF, read 0x14 -> 0x12345678. Writing address 0x0000_1000 -> reads 0 and RAM is unchanged.
REQ-030 Timer: write CMP=20, STAT=0x2, CNT=0.
  - The flag sets 21 edges after the CNT write edge, and timer_irq=1.
  - Writing STAT=0x3 clears the flag while the enable stays 1.
  - With CMP=0, no flag is ever set.
REQ-031 Timer race: hold the STAT=0x1 write on the exact edge the flag would set -> flag remains 1.
REQ-032 Wrap: force CNT near its maximum by waiting from a reset-released count, or by a bench backdoor at 0xFFFF_FFFE. After 2 edges CNT reads 0x0000_0000. With CMP=0xFFFF_FFFF, the flag sets on the wrap edge.
REQ-033 GPIO: write GOUT=0x1A5 -> gpio_out=0xA5 (GPIO_W=8). Set gpio_in=0x3C -> GIN reads 0x3C after 2 edges, and 0x00 or the old value before.
REQ-034 Async reset: assert reset=0 mid-cycle after setup -> gpio_out, timer_irq and CNT go 0 immediately, without a clk edge. A RAM word written before reset still reads its value afterwards.
